// File: rtl/reg_transfer_sequencer_pkg.sv
// rtl/reg_transfer_sequencer_pkg.sv - shared op codes, state encoding and index helper
package seq_defs;

    typedef enum logic [1:0] {
        OP_MOV = 2'd0,
        OP_ALU = 2'd1,
        OP_LDI = 2'd2,
        OP_NOP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_ALU_SEL = 2'd2,
        ST_ALU_WB  = 2'd3
    } state_e;

    function automatic logic idx_oob(input int idx, input int nreg);
        return idx >= nreg;
    endfunction

endpackage

// File: rtl/idx_to_strobe_n.sv
// rtl/idx_to_strobe_n.sv - index to active-low one-hot strobe decoder with enable
module idx_to_strobe_n #(
    parameter int NREG  = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREG-1:0]  strobe_n_o
);

    // Indices with no matching register simply never match, leaving all-ones.
    always_comb begin
        strobe_n_o = '1;
        for (int i = 0; i < NREG; i++) begin
            if (en_i && (idx_i == IDX_W'(i))) begin
                strobe_n_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// rtl/reg_transfer_sequencer.sv - sequences registered active-low register-file strobes per command
module reg_transfer_sequencer
    import seq_defs::*;
#(
    parameter int NREG  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_dst,
    input  logic [IDX_W-1:0] cmd_a,
    input  logic [IDX_W-1:0] cmd_b,
    input  logic [7:0]       cmd_imm,
    output logic [NREG-1:0]  outn,
    output logic [NREG-1:0]  loadn,
    output logic [NREG-1:0]  loutn,
    output logic [NREG-1:0]  routn,
    output logic             alu_outn,
    output logic             flags_loadn,
    output logic             imm_outn,
    output logic [7:0]       imm,
    output logic             err
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] b_q, b_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [7:0]       imm_q, imm_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  outn_q, loadn_q, loutn_q, routn_q;
    logic [NREG-1:0]  outn_d, loadn_d, loutn_d, routn_d;
    logic             alu_outn_q, flags_loadn_q, imm_outn_q;
    logic             alu_outn_d, flags_loadn_d, imm_outn_d;

    logic             accept;
    logic             bad_idx;
    logic             out_en, load_en, opnd_en;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Only indices the op actually uses can flag an error.
    always_comb begin
        bad_idx = 1'b0;
        case (op_e'(cmd_op))
            OP_MOV:  bad_idx = idx_oob(int'(cmd_a), NREG) || idx_oob(int'(cmd_dst), NREG);
            OP_ALU:  bad_idx = idx_oob(int'(cmd_a), NREG) || idx_oob(int'(cmd_b), NREG)
                               || idx_oob(int'(cmd_dst), NREG);
            OP_LDI:  bad_idx = idx_oob(int'(cmd_dst), NREG);
            default: bad_idx = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        err_d   = err_q | (accept & bad_idx);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op_e'(cmd_op);
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    dst_d = cmd_dst;
                    case (op_e'(cmd_op))
                        OP_MOV:  state_d = ST_XFER;
                        OP_LDI: begin
                            state_d = ST_XFER;
                            imm_d   = cmd_imm;
                        end
                        OP_ALU:  state_d = ST_ALU_SEL;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_XFER:    state_d = ST_IDLE;
            ST_ALU_SEL: state_d = ST_ALU_WB;
            ST_ALU_WB:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register in the same edge.
    assign out_en        = (state_d == ST_XFER) && (op_d == OP_MOV);
    assign load_en       = (state_d == ST_XFER) || (state_d == ST_ALU_WB);
    assign opnd_en       = (state_d == ST_ALU_SEL) || (state_d == ST_ALU_WB);
    assign alu_outn_d    = !(state_d == ST_ALU_WB);
    assign flags_loadn_d = !(state_d == ST_ALU_WB);
    assign imm_outn_d    = !((state_d == ST_XFER) && (op_d == OP_LDI));

    idx_to_strobe_n #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_out (
        .idx_i      (a_d),
        .en_i       (out_en),
        .strobe_n_o (outn_d)
    );

    idx_to_strobe_n #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_load (
        .idx_i      (dst_d),
        .en_i       (load_en),
        .strobe_n_o (loadn_d)
    );

    idx_to_strobe_n #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_lout (
        .idx_i      (a_d),
        .en_i       (opnd_en),
        .strobe_n_o (loutn_d)
    );

    idx_to_strobe_n #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_rout (
        .idx_i      (b_d),
        .en_i       (opnd_en),
        .strobe_n_o (routn_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            a_q           <= '0;
            b_q           <= '0;
            dst_q         <= '0;
            imm_q         <= 8'h00;
            err_q         <= 1'b0;
            outn_q        <= '1;
            loadn_q       <= '1;
            loutn_q       <= '1;
            routn_q       <= '1;
            alu_outn_q    <= 1'b1;
            flags_loadn_q <= 1'b1;
            imm_outn_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            dst_q         <= dst_d;
            imm_q         <= imm_d;
            err_q         <= err_d;
            outn_q        <= outn_d;
            loadn_q       <= loadn_d;
            loutn_q       <= loutn_d;
            routn_q       <= routn_d;
            alu_outn_q    <= alu_outn_d;
            flags_loadn_q <= flags_loadn_d;
            imm_outn_q    <= imm_outn_d;
        end
    end

    assign outn        = outn_q;
    assign loadn       = loadn_q;
    assign loutn       = loutn_q;
    assign routn       = routn_q;
    assign alu_outn    = alu_outn_q;
    assign flags_loadn = flags_loadn_q;
    assign imm_outn    = imm_outn_q;
    assign imm         = imm_q;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// tb/tb_reg_transfer_sequencer.sv - vector table, corner sequences and random stream against a cycle-list model
module tb_reg_transfer_sequencer;

    localparam int NREG  = 4;
    localparam int IDX_W = 3;

    logic             clk;
    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_dst, cmd_a, cmd_b;
    logic [7:0]       cmd_imm;
    logic [NREG-1:0]  outn, loadn, loutn, routn;
    logic             alu_outn, flags_loadn, imm_outn;
    logic [7:0]       imm;
    logic             err;

    reg_transfer_sequencer #(.NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_imm     (cmd_imm),
        .outn        (outn),
        .loadn       (loadn),
        .loutn       (loutn),
        .routn       (routn),
        .alu_outn    (alu_outn),
        .flags_loadn (flags_loadn),
        .imm_outn    (imm_outn),
        .imm         (imm),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // One record per busy cycle still to come; the front is the current cycle.
    typedef struct {
        logic [3:0] outn, loadn, loutn, routn;
        logic       alun, flagn, immn;
    } cyc_t;

    cyc_t       exp_q[$];
    logic       m_err = 1'b0;
    logic [7:0] m_imm = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.outn = 4'hF; c.loadn = 4'hF; c.loutn = 4'hF; c.routn = 4'hF;
        c.alun = 1'b1; c.flagn = 1'b1; c.immn = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] sel_n(input int idx);
        logic [3:0] v;
        v = 4'hF;
        if (idx < NREG) v[idx] = 1'b0;
        return v;
    endfunction

    task automatic model_accept(input int op, input int a, input int b, input int dst, input logic [7:0] im);
        cyc_t c;
        c = idle_cyc();
        case (op)
            0: begin
                c.outn = sel_n(a); c.loadn = sel_n(dst);
                exp_q.push_back(c);
                if (a >= NREG || dst >= NREG) m_err = 1'b1;
            end
            1: begin
                c.loutn = sel_n(a); c.routn = sel_n(b);
                exp_q.push_back(c);
                c.alun = 1'b0; c.flagn = 1'b0; c.loadn = sel_n(dst);
                exp_q.push_back(c);
                if (a >= NREG || b >= NREG || dst >= NREG) m_err = 1'b1;
            end
            2: begin
                c.immn = 1'b0; c.loadn = sel_n(dst);
                exp_q.push_back(c);
                m_imm = im;
                if (dst >= NREG) m_err = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        cyc_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : idle_cyc();
        check("strobes", {outn, loadn, loutn, routn, alu_outn, flags_loadn, imm_outn},
              {e.outn, e.loadn, e.loutn, e.routn, e.alun, e.flagn, e.immn});
        check("err_imm_ready", {err, imm, cmd_ready}, {m_err, m_imm, exp_q.size() == 0});
        check("bus_driver", ($countones(~outn) + (!alu_outn ? 1 : 0) + (!imm_outn ? 1 : 0)) <= 1, 1);
        check("onehot_low", ($countones(~outn) <= 1) && ($countones(~loadn) <= 1)
              && ($countones(~loutn) <= 1) && ($countones(~routn) <= 1), 1);
    endtask

    task automatic tick();
        logic acc;
        int op, a, b, dst;
        logic [7:0] im;
        acc = resetn && cmd_valid && (exp_q.size() == 0);
        op = int'(cmd_op); a = int'(cmd_a); b = int'(cmd_b); dst = int'(cmd_dst); im = cmd_imm;
        @(posedge clk);
        #1;
        if (!resetn) begin
            exp_q.delete();
            m_err = 1'b0;
            m_imm = 8'h00;
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) model_accept(op, a, b, dst, im);
        end
        compare_all();
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] a, b, dst;
        logic [7:0] im;
        logic [3:0] e_outn, e_loadn, e_loutn, e_routn;
        logic       e_alun, e_immn, e_err;
        logic [7:0] e_imm;
        int         busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int busy;

        tbl[0] = '{2'd0, 3'd1, 3'd0, 3'd2, 8'h00, 4'b1111 & 4'b1101, 4'b1011, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        tbl[1] = '{2'd2, 3'd0, 3'd0, 3'd3, 8'hA5, 4'hF, 4'b0111, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 8'hA5, 1};
        tbl[2] = '{2'd1, 3'd0, 3'd0, 3'd0, 8'h11, 4'hF, 4'hF, 4'b1110, 4'b1110, 1'b1, 1'b1, 1'b0, 8'hA5, 2};
        tbl[3] = '{2'd0, 3'd5, 3'd0, 3'd1, 8'h22, 4'hF, 4'b1101, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
        tbl[4] = '{2'd0, 3'd3, 3'd0, 3'd0, 8'h33, 4'b0111, 4'b1110, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
        tbl[5] = '{2'd3, 3'd1, 3'd2, 3'd3, 8'h44, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 8'hA5, 0};
        tbl[6] = '{2'd1, 3'd2, 3'd3, 3'd1, 8'h55, 4'hF, 4'hF, 4'b1011, 4'b0111, 1'b1, 1'b1, 1'b1, 8'hA5, 2};
        tbl[7] = '{2'd2, 3'd1, 3'd2, 3'd0, 8'h3C, 4'hF, 4'b1110, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 8'h3C, 1};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd3;
        cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_imm = 8'h00;
        tick();
        tick();
        check("reset_values", {outn, loadn, loutn, routn, alu_outn, flags_loadn, imm_outn, err, imm, cmd_ready},
              {16'hFFFF, 3'b111, 1'b0, 8'h00, 1'b1});
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_op = tbl[i].op; cmd_a = tbl[i].a; cmd_b = tbl[i].b;
            cmd_dst = tbl[i].dst; cmd_imm = tbl[i].im;
            tick();
            cmd_valid = 1'b0;
            check("tbl_strobes", {outn, loadn, loutn, routn, alu_outn, imm_outn},
                  {tbl[i].e_outn, tbl[i].e_loadn, tbl[i].e_loutn, tbl[i].e_routn, tbl[i].e_alun, tbl[i].e_immn});
            check("tbl_err_imm", {err, imm}, {tbl[i].e_err, tbl[i].e_imm});
            busy = 0;
            while (!cmd_ready && busy < 5) begin
                tick();
                busy++;
            end
            check("tbl_busy_cycles", busy, tbl[i].busy);
        end

        // Back-to-back NOPs are taken every cycle.
        cmd_valid = 1'b1; cmd_op = 2'd3;
        for (int i = 0; i < 3; i++) tick();
        cmd_valid = 1'b0;

        // Reset asserted asynchronously during ALU writeback.
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 3'd1; cmd_b = 3'd2; cmd_dst = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("in_alu_wb", {alu_outn, flags_loadn, loadn}, {1'b0, 1'b0, 4'b0111});
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        m_err = 1'b0;
        m_imm = 8'h00;
        compare_all();
        check("async_reset", {outn, loadn, loutn, routn, alu_outn, flags_loadn, imm_outn, err, imm},
              {16'hFFFF, 3'b111, 1'b0, 8'h00});
        tick();
        resetn = 1'b1;
        tick();
        tick();

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 300; i++) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_a     = 3'($urandom_range(0, (pass == 0) ? 3 : 4));
                cmd_b     = 3'($urandom_range(0, 3));
                cmd_dst   = 3'($urandom_range(0, (pass == 0) ? 3 : 4));
                cmd_imm   = 8'($urandom);
                tick();
            end
            cmd_valid = 1'b0;
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_transfer_sequencer.md
# reg_transfer_sequencer

Control-side initiator for the general-purpose register file: accepts one register-level command per handshake and sequences the active-low strobes (`outn`, `loadn`, `loutn`, `routn`) that the gp registers respond to. It also drives the strobes for the ALU result buffer, the flags register and the immediate buffer. It sits between the instruction decoder and the register file, and is the only block that drives register control lines.

## Interface
- `NREG`, default 4: number of gp registers controlled.
- `IDX_W`, default 2: register index width; must satisfy 2^IDX_W >= NREG.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer idle and able to accept.
- `cmd_op`  in  2: 0 MOV, 1 ALU, 2 LDI, 3 NOP.
- `cmd_dst`, `cmd_a`, `cmd_b`  in  IDX_W each: destination, source/left operand, right operand.
- `cmd_imm`  in  8: immediate value for LDI.
- `outn`  out  NREG: per-register bus output enable, active-low.
- `loadn`  out  NREG: per-register bus load, active-low.
- `loutn`  out  NREG: per-register ALU-left enable, active-low.
- `routn`  out  NREG: per-register ALU-right enable, active-low.
- `alu_outn`  out  1: ALU result onto bus, active-low.
- `flags_loadn`  out  1: flags register load, active-low.
- `imm_outn`  out  1: immediate buffer onto bus, active-low.
- `imm`  out  8: latched immediate.
- `err`  out  1: sticky; set on any accepted command with an index >= NREG.

## Operation
- States: IDLE, XFER, ALU_SEL, ALU_WB.
- `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid` && `cmd_ready` && `resetn`.
- Fields are latched on acceptance. `imm` is loaded from `cmd_imm` only for LDI and holds otherwise.
- MOV and LDI move IDLE->XFER->IDLE.
  - XFER for MOV: `outn[a]`=0, `loadn[dst]`=0.
  - XFER for LDI: `imm_outn`=0, `loadn[dst]`=0.
- ALU moves IDLE->ALU_SEL->ALU_WB->IDLE.
  - ALU_SEL: `loutn[a]`=0, `routn[b]`=0.
  - ALU_WB: `loutn[a]` and `routn[b]` stay 0; `alu_outn`=0, `loadn[dst]`=0, `flags_loadn`=0.
- NOP is accepted and stays in IDLE; no strobe asserts.
- `a == dst` (MOV) is legal and reloads the same value. `a == b` (ALU) is legal; both `loutn[a]` and `routn[a]` assert.
- An index >= NREG sets `err`. The command still runs its full sequence, but strobes for the out-of-range index stay high.
- Invariant: in every cycle, at most one of {any `outn`, `alu_outn`, `imm_outn`} is low (single bus driver). At most one bit of each strobe vector is low.
- `resetn` low at any time:
  - all strobes go to 1 immediately;
  - state goes to IDLE; an in-flight command is dropped with no partial strobe;
  - `err`=0, `imm`=0.

## Timing
- All strobe outputs are registered, so they are glitch-free and change only on `clk` rise or async reset.
- Reset values: every `*n` output 1, `err` 0, `imm` 0x00, `cmd_ready` 1.
- Accept at edge E0:
  - MOV/LDI: strobes valid E0..E1; the target captures at E1; `cmd_ready` high after E1. Throughput is one command per 2 cycles.
  - ALU: select E0..E1, writeback E1..E2; dst and flags capture at E2; `cmd_ready` high after E2. Throughput is one command per 3 cycles.
  - NOP: `cmd_ready` stays high, so back-to-back NOPs are accepted every cycle.
- The ALU_SEL cycle gives operand registers a half-cycle for their secondary (inverted-clock) copies to settle before the result is written back.
- When `dst` is an operand, its ALU-side copy is unchanged until after E2, so the operand stays stable through writeback.

## Structure
- Shared package `seq_defs`: op codes OP_MOV/OP_ALU/OP_LDI/OP_NOP and the state encoding.
- Sub-module `idx_to_strobe_n`: an IDX_W-to-NREG active-low one-hot decoder with enable. It outputs all-ones when the index is >= NREG or the enable is low.
- It is instantiated four times (`outn`, `loadn`, `loutn`, `routn`), with outputs registered in the parent.

## Test plan
- Reset then MOV a=1 dst=2 → after E0: `outn`=1101, `loadn`=1011 for exactly 1 cycle. `cmd_ready` is 0 during that cycle and 1 after E1.
- LDI imm=0xA5 dst=3 → `imm`=0xA5, `imm_outn`=0, `loadn`=0111 for 1 cycle, all `outn`=1111.
- ALU a=0 b=0 dst=0 → ALU_SEL: `loutn`=`routn`=1110. ALU_WB: same, plus `alu_outn`=`flags_loadn`=0 and `loadn`=1110. Idle after 2 cycles.
- MOV a=5 dst=1 with NREG=4 → `err`=1 and sticky; `outn` stays 1111, `loadn`=1101. A following valid MOV still executes.
- Assert `resetn` low mid ALU_WB → all strobes 1 asynchronously, `err`=0. After release: IDLE, `cmd_ready`=1, no residual strobe.
- Random command stream with `cmd_valid` toggling → scoreboard of strobe sequences; check the single-bus-driver invariant and the one-hot-low invariant every cycle.
